data_ram_mmio: RTL and testbench

- Responder for the CPU core's data-memory port (ce/we/addr/sel/data).
- Provides word-organised data RAM with byte-lane writes.
- Decodes a small memory-mapped I/O window containing a cycle counter, a compare/timer-interrupt register and a debug TX byte FIFO with a valid/ready drain port.
- Sits at top level between the core's ram_* pins and the SoC's debug/console sink.

---
 rtl/data_ram_mmio_pkg.sv | 39 +++
 rtl/data_ram_mmio_tx_byte_fifo.sv | 57 +++++
 rtl/data_ram_mmio.sv | 160 ++++++++++++++++
 tb/tb_data_ram_mmio.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/data_ram_mmio_pkg.sv
// Shared definitions for the data-memory responder: register bus width,
// MMIO register offsets, STATUS bit positions and the default window base.
// Also provides the byte-lane merge helper used by every writable register.
package data_ram_mmio_pkg;

    // Register bus width, identical to the core's data-memory data path
    localparam int REG_W = 32;

    // addr[31:28] value that selects the MMIO window
    localparam logic [3:0] MMIO_BASE_DEFAULT = 4'h1;

    // Word-aligned register offsets inside the window
    localparam logic [3:0] OFF_COUNT   = 4'h0;
    localparam logic [3:0] OFF_COMPARE = 4'h4;
    localparam logic [3:0] OFF_STATUS  = 4'h8;
    localparam logic [3:0] OFF_TXDATA  = 4'hC;

    // STATUS register bit positions
    localparam int ST_IRQ     = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_OCC_LSB = 4;   // 4-bit FIFO occupancy field

    // Replace the bytes of cur whose lane is selected with the bytes of wdat
    function automatic logic [REG_W-1:0] byte_merge(
        input logic [REG_W-1:0]   cur,
        input logic [REG_W-1:0]   wdat,
        input logic [REG_W/8-1:0] sel
    );
        logic [REG_W-1:0] res;
        res = cur;
        for (int i = 0; i < REG_W/8; i++) begin
            if (sel[i]) res[8*i +: 8] = wdat[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/data_ram_mmio_tx_byte_fifo.sv
// Byte FIFO feeding the debug TX drain port.
// Latency: a byte pushed into an empty FIFO appears on head the next cycle.
// Backpressure: push while full is accepted only together with a pop; otherwise ignored.
//
// Ports: clk/rst_n (async active-low), push + push_dat in, pop in,
//        full/empty/count status out, head_dat = oldest stored byte.
module tx_byte_fifo #(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [7:0]  push_dat,
    input  logic        pop,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count,
    output logic [7:0]  head_dat
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;
    logic          do_push;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign head_dat = mem[rd_ptr];

    // A pop from an empty FIFO is meaningless; a push into a full FIFO
    // only fits when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/data_ram_mmio.sv
// Data-memory responder: word RAM with byte-lane writes plus MMIO timer and debug TX FIFO.
// Latency: reads are combinational (same cycle); writes take effect on the next clk edge.
// Backpressure: the core port never stalls; TX drains by valid/ready, pushes to a full FIFO drop and flag overflow.
//
// Ports: clk, rst (async active-low); core side mem_ce_i/we_i/addr_i/sel_i/data_i
//        with combinational mem_data_o; timer_irq_o level; tx_valid_o/tx_data_o/tx_ready_i drain.
module data_ram_mmio
    import data_ram_mmio_pkg::*;
#(
    parameter int         RAM_AW     = 10,
    parameter logic [3:0] MMIO_BASE  = MMIO_BASE_DEFAULT,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        timer_irq_o,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [REG_W-1:0] ram [2**RAM_AW];
    logic [RAM_AW-1:0] ram_idx;

    logic [REG_W-1:0] count;
    logic [REG_W-1:0] compare;
    logic             irq;
    logic             ovf;

    logic             acc_wr;
    logic             acc_rd;
    logic             is_mmio;
    logic             reg_hit;
    logic [3:0]       reg_off;
    logic             ram_wr;
    logic             count_wr;
    logic             compare_wr;
    logic             status_wr;
    logic             irq_set;
    logic             irq_clr;
    logic             ovf_set;
    logic             ovf_clr;
    logic             tx_push;
    logic             tx_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic [REG_W-1:0] status_vec;
    logic             unused_addr_lsbs;

    // Byte offset bits are irrelevant for a word-organised port
    assign unused_addr_lsbs = &{1'b0, mem_addr_i[1:0]};

    // ---------------- decode ----------------
    assign acc_wr  = mem_ce_i & mem_we_i;
    assign acc_rd  = mem_ce_i & ~mem_we_i;
    assign is_mmio = (mem_addr_i[31:28] == MMIO_BASE);
    // Only the first 16 bytes of the window hold registers; the rest is a hole
    assign reg_hit = is_mmio && (mem_addr_i[27:4] == '0);
    assign reg_off = {mem_addr_i[3:2], 2'b00};
    assign ram_idx = mem_addr_i[RAM_AW+1:2];

    assign ram_wr     = acc_wr & ~is_mmio;
    assign count_wr   = acc_wr & reg_hit & (reg_off == OFF_COUNT);
    assign compare_wr = acc_wr & reg_hit & (reg_off == OFF_COMPARE);
    assign status_wr  = acc_wr & reg_hit & (reg_off == OFF_STATUS) & mem_sel_i[0];
    assign tx_push    = acc_wr & reg_hit & (reg_off == OFF_TXDATA) & mem_sel_i[0];

    // ---------------- RAM (contents survive reset) ----------------
    always_ff @(posedge clk) begin
        if (ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_sel_i[i]) ram[ram_idx][8*i +: 8] <= mem_data_i[8*i +: 8];
            end
        end
    end

    // ---------------- timer ----------------
    assign irq_set = (compare != '0) && (count == compare);
    assign irq_clr = status_wr & mem_data_i[ST_IRQ];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count   <= '0;
            compare <= '0;
            irq     <= 1'b0;
        end else begin
            // A write replaces the increment; unwritten lanes hold their old value
            if (count_wr) count <= byte_merge(count, mem_data_i, mem_sel_i);
            else          count <= count + REG_W'(1);
            if (compare_wr) compare <= byte_merge(compare, mem_data_i, mem_sel_i);
            // Set has priority so a clear racing a new match cannot lose the event
            if (irq_set)      irq <= 1'b1;
            else if (irq_clr) irq <= 1'b0;
        end
    end

    assign timer_irq_o = irq;

    // ---------------- TX FIFO ----------------
    assign tx_valid_o = ~fifo_empty;
    assign tx_pop     = tx_valid_o & tx_ready_i;
    assign ovf_set    = tx_push & fifo_full & ~tx_pop;
    assign ovf_clr    = status_wr & mem_data_i[ST_OVF];

    tx_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk      (clk),
        .rst_n    (rst),
        .push     (tx_push),
        .push_dat (mem_data_i[7:0]),
        .pop      (tx_pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .head_dat (tx_data_o)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         ovf <= 1'b0;
        else if (ovf_set) ovf <= 1'b1;
        else if (ovf_clr) ovf <= 1'b0;
    end

    // ---------------- read path ----------------
    always_comb begin
        status_vec                      = '0;
        status_vec[ST_IRQ]              = irq;
        status_vec[ST_FULL]             = fifo_full;
        status_vec[ST_EMPTY]            = fifo_empty;
        status_vec[ST_OVF]              = ovf;
        status_vec[ST_OCC_LSB +: 4]     = 4'(fifo_count);
    end

    always_comb begin
        mem_data_o = '0;
        if (acc_rd) begin
            if (!is_mmio) begin
                mem_data_o = ram[ram_idx];
            end else if (reg_hit) begin
                case (reg_off)
                    OFF_COUNT:   mem_data_o = count;
                    OFF_COMPARE: mem_data_o = compare;
                    OFF_STATUS:  mem_data_o = status_vec;
                    default:     mem_data_o = '0;   // TXDATA is write-only
                endcase
            end
        end
    end

endmodule

// File: tb/tb_data_ram_mmio.sv
// Directed bench for data_ram_mmio: RAM lanes/aliasing, counter/timer, TX FIFO, async reset.
// Expected read words and TX bytes are queued when stimulus is driven and popped at compare time.
// Inputs change on the falling edge; outputs are sampled 1 time unit after that.
module tb_data_ram_mmio;

    localparam logic [31:0] MB       = 32'h1000_0000;
    localparam logic [31:0] A_COUNT  = MB + 32'h0;
    localparam logic [31:0] A_CMP    = MB + 32'h4;
    localparam logic [31:0] A_STATUS = MB + 32'h8;
    localparam logic [31:0] A_TX     = MB + 32'hC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_ce_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [31:0] mem_addr_i = '0;
    logic [3:0]  mem_sel_i = '0;
    logic [31:0] mem_data_i = '0;
    logic [31:0] mem_data_o;
    logic        timer_irq_o;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        tx_ready_i = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  tx_q[$];

    always #5 clk = ~clk;

    data_ram_mmio dut (
        .clk         (clk),
        .rst         (rst),
        .mem_ce_i    (mem_ce_i),
        .mem_we_i    (mem_we_i),
        .mem_addr_i  (mem_addr_i),
        .mem_sel_i   (mem_sel_i),
        .mem_data_i  (mem_data_i),
        .mem_data_o  (mem_data_o),
        .timer_irq_o (timer_irq_o),
        .tx_valid_o  (tx_valid_o),
        .tx_data_o   (tx_data_o),
        .tx_ready_i  (tx_ready_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One write cycle, starting at the current time and ending at the next falling edge
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = a; mem_data_i = d; mem_sel_i = s;
        @(negedge clk);
        mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_sel_i = '0;
    endtask

    // One read cycle; expected word goes through the scoreboard queue
    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] expv);
        exp_q.push_back(expv);
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = a; mem_sel_i = '0;
        #1;
        check(tag, mem_data_o, exp_q.pop_front());
        @(negedge clk);
        mem_ce_i = 1'b0;
    endtask

    task automatic push_tx(input logic [7:0] b, input bit accepted);
        if (accepted) tx_q.push_back(b);
        wr(A_TX, {24'h0, b}, 4'b0001);
    endtask

    // TX scoreboard: every handshake must deliver the next expected byte
    always begin
        @(negedge clk);
        #1;
        if (rst && tx_valid_o && tx_ready_i) begin
            if (tx_q.size() == 0) check("tx_extra_byte", 32'(tx_q.size()), 32'd1);
            else                  check("tx_byte", 32'(tx_data_o), 32'(tx_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        // ---------------- reset ----------------
        #2 rst = 1'b0;
        #1;
        check("rst_irq", 32'(timer_irq_o), 32'd0);
        check("rst_tx_valid", 32'(tx_valid_o), 32'd0);
        check("rst_tx_data", 32'(tx_data_o), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        rd("rst_count", A_COUNT, 32'h0);
        rd("rst_status", A_STATUS, 32'h0000_0004);

        // ---------------- RAM byte lanes ----------------
        wr(32'h0000_0010, 32'hAABB_CCDD, 4'hF);
        wr(32'h0000_0010, 32'h1122_3344, 4'b0101);
        rd("ram_lanes", 32'h0000_0010, 32'hAA22_CC44);
        mem_ce_i = 1'b0; mem_addr_i = 32'h0000_0010;
        #1 check("ram_ce0", mem_data_o, 32'h0);
        @(negedge clk);
        mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'h0; mem_data_i = 32'hFFFF_FFFF;
        #1 check("ram_we1_out", mem_data_o, 32'h0);
        @(negedge clk);
        mem_ce_i = 1'b0; mem_we_i = 1'b0;
        rd("ram_sel0_nowrite", 32'h0000_0010, 32'hAA22_CC44);

        // ---------------- aliasing ----------------
        wr(32'h0000_0000, 32'h5, 4'hF);
        rd("ram_alias", 32'h0000_1000, 32'h5);
        rd("mmio_hole", MB + 32'h10, 32'h0);

        // ---------------- counter / timer ----------------
        wr(A_COUNT, 32'hFFFF_FFFE, 4'hF);
        wr(A_CMP, 32'h0000_0003, 4'hF);
        rd("count_ffff", A_COUNT, 32'hFFFF_FFFF);
        rd("count_wrap", A_COUNT, 32'h0);
        rd("count_1", A_COUNT, 32'h1);
        rd("count_2", A_COUNT, 32'h2);
        check("irq_before", 32'(timer_irq_o), 32'd0);
        rd("count_3", A_COUNT, 32'h3);
        #1 check("irq_rise", 32'(timer_irq_o), 32'd1);
        wr(A_STATUS, 32'h1, 4'b0001);
        #1 check("irq_w1c", 32'(timer_irq_o), 32'd0);
        wr(A_COUNT, 32'h0000_0100, 4'hF);
        wr(A_CMP, 32'h0000_0104, 4'hF);
        repeat (3) @(negedge clk);
        #1 check("irq_pre_set", 32'(timer_irq_o), 32'd0);
        wr(A_STATUS, 32'h1, 4'b0001);          // lands on the set edge
        #1 check("irq_set_wins", 32'(timer_irq_o), 32'd1);
        wr(A_STATUS, 32'h1, 4'b0001);
        #1 check("irq_clear2", 32'(timer_irq_o), 32'd0);

        // ---------------- FIFO fill / overflow / drain ----------------
        @(negedge clk);
        tx_ready_i = 1'b0;
        push_tx("A", 1'b1);
        push_tx("B", 1'b1);
        push_tx("C", 1'b1);
        push_tx("D", 1'b1);
        rd("status_full", A_STATUS, 32'h0000_0042);
        check("tx_head_A", 32'(tx_data_o), 32'h41);
        push_tx("E", 1'b0);
        rd("status_ovf", A_STATUS, 32'h0000_004A);
        tx_ready_i = 1'b1;
        repeat (6) @(negedge clk);
        tx_ready_i = 1'b0;
        #1 check("tx_valid_drained", 32'(tx_valid_o), 32'd0);
        rd("status_empty_ovf", A_STATUS, 32'h0000_000C);
        wr(A_STATUS, 32'h8, 4'b0001);
        rd("status_ovf_clr", A_STATUS, 32'h0000_0004);

        // ---------------- full push+pop ----------------
        push_tx("1", 1'b1);
        push_tx("2", 1'b1);
        push_tx("3", 1'b1);
        push_tx("4", 1'b1);
        tx_ready_i = 1'b1;
        push_tx("X", 1'b1);
        tx_ready_i = 1'b0;
        rd("status_full_pp", A_STATUS, 32'h0000_0042);
        tx_ready_i = 1'b1;
        repeat (6) @(negedge clk);
        tx_ready_i = 1'b0;
        check("tx_q_empty", 32'(tx_q.size()), 32'd0);

        // ---------------- async reset mid-drain ----------------
        push_tx("P", 1'b1);
        push_tx("Q", 1'b1);
        push_tx("R", 1'b1);
        wr(A_CMP, 32'h0000_0021, 4'hF);
        wr(A_COUNT, 32'h0000_0021, 4'hF);
        @(negedge clk);
        #1 check("irq_pre_rst", 32'(timer_irq_o), 32'd1);
        @(negedge clk);
        tx_ready_i = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_tx_valid", 32'(tx_valid_o), 32'd0);
        check("arst_irq", 32'(timer_irq_o), 32'd0);
        check("arst_tx_data", 32'(tx_data_o), 32'd0);
        tx_q.delete();
        tx_ready_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        rd("post_rst_count", A_COUNT, 32'h0);
        rd("post_rst_cmp", A_CMP, 32'h0);
        rd("post_rst_status", A_STATUS, 32'h0000_0004);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
